seg_scan_driver: RTL and testbench

Parametrised multi-digit 7-segment scan driver. It time-multiplexes N digits over a serial shift-register chain such as 74HC595 pairs. For each digit it builds one {SEG, DIGIT} word with configurable polarity and per-digit blanking. It then hands the word to the shift-register block with a start/busy handshake and holds each digit for a programmable dwell time. It sits between the display-formatting logic (segment codes per digit) and the shift-register serialiser.

---
 rtl/seg_scan_driver_if.sv | 32 +++
 rtl/seg_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Segment scan bus: display-side inputs, shifter handshake and scan status.
// Latency: n/a (signal bundle only).
// Backpressure: the shifter holds off the driver through busy.
//
// master: the scan driver (drives data_out/start/status, reads codes/busy)
// slave : the environment (formatter + shift-register serialiser)
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8,
    parameter int SEG_W      = 8
);
    localparam int CW = $clog2(NUM_DIGITS);

    logic                        en;
    logic [NUM_DIGITS*SEG_W-1:0] seg_bus;
    logic [NUM_DIGITS-1:0]       blank_mask;
    logic                        busy;
    logic [SEG_W+NUM_DIGITS-1:0] data_out;
    logic                        start;
    logic [CW-1:0]               cur_digit;
    logic                        frame_done;
    logic                        ack_err;

    modport master (
        input  en, seg_bus, blank_mask, busy,
        output data_out, start, cur_digit, frame_done, ack_err
    );

    modport slave (
        output en, seg_bus, blank_mask, busy,
        input  data_out, start, cur_digit, frame_done, ack_err
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multi-digit 7-segment scan driver feeding a serial shift-register chain.
// Latency: start rises 2 cycles after leaving IDLE/DWELL when busy is low.
// Backpressure: start is withheld while busy=1; each word is held until busy falls.
//
// Ports: i_clk, i_rst (sync, active-high), bus (seg_scan_driver_if.master):
//   en, seg_bus, blank_mask, busy in; data_out {seg,dig}, start, cur_digit,
//   frame_done, ack_err (sticky) out.
module seg_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_W          = 8,
    parameter int DWELL_CYCLES   = 2000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter int ACK_TIMEOUT    = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    seg_scan_driver_if.master   bus
);
    localparam int CW  = $clog2(NUM_DIGITS);
    localparam int DW  = SEG_W + NUM_DIGITS;
    localparam int CTW = $clog2(DWELL_CYCLES + 1);
    localparam int TOW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [SEG_W-1:0]      SEG_OFF    = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [DW-1:0]         OFF_WORD   = {SEG_OFF, DIG_OFF};
    localparam logic [CW-1:0]         LAST_DIG   = CW'(NUM_DIGITS - 1);
    localparam logic [CTW-1:0]        DWELL_LAST = CTW'(DWELL_CYCLES - 1);
    localparam logic [TOW-1:0]        TO_LAST    = TOW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_ACK, S_WAIT_DONE, S_DWELL, S_BLANK
    } state_t;

    state_t                      r_state;
    logic [DW-1:0]               r_data;
    logic                        r_start;
    logic [CW-1:0]               r_cur;
    logic                        r_fd;
    logic                        r_ack_err;
    logic [CTW-1:0]              r_dwell;
    logic [TOW-1:0]              r_to;
    logic                        r_exit;   // set during the single blanking pass
    logic [NUM_DIGITS*SEG_W-1:0] r_snap_seg;
    logic [NUM_DIGITS-1:0]       r_snap_blank;

    logic [DW-1:0]               w_load_word;

    // XOR with the inactive pattern flips an active-high code into the
    // output polarity; the digit select is a one-hot flipped the same way.
    function automatic logic [DW-1:0] f_word(
        input logic [NUM_DIGITS*SEG_W-1:0] codes,
        input logic [NUM_DIGITS-1:0]       blank,
        input logic [CW-1:0]               idx
    );
        logic [SEG_W-1:0]      seg;
        logic [NUM_DIGITS-1:0] dig;
        seg = blank[idx] ? SEG_OFF : (codes[idx*SEG_W +: SEG_W] ^ SEG_OFF);
        dig = DIG_OFF ^ ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
        return {seg, dig};
    endfunction

    // Digit 0 builds from the live bus in the same cycle it is snapshotted,
    // so the whole frame comes from one consistent capture.
    assign w_load_word = (r_cur == '0) ? f_word(bus.seg_bus, bus.blank_mask, r_cur)
                                       : f_word(r_snap_seg, r_snap_blank, r_cur);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_data       <= OFF_WORD;
            r_start      <= 1'b0;
            r_cur        <= '0;
            r_fd         <= 1'b0;
            r_ack_err    <= 1'b0;
            r_dwell      <= '0;
            r_to         <= '0;
            r_exit       <= 1'b0;
            r_snap_seg   <= '0;
            r_snap_blank <= '0;
        end else begin
            r_start <= 1'b0;
            r_fd    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_exit <= 1'b0;
                    if (bus.en) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (r_cur == '0) begin
                        r_snap_seg   <= bus.seg_bus;
                        r_snap_blank <= bus.blank_mask;
                    end
                    r_data  <= w_load_word;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (!bus.busy) begin
                        r_start <= 1'b1;
                        r_to    <= '0;
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (bus.busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_to == TO_LAST) begin
                        // Shifter never acknowledged: flag it and move on as
                        // if the transfer had completed.
                        r_ack_err <= 1'b1;
                        r_dwell   <= '0;
                        r_state   <= r_exit ? S_IDLE : S_DWELL;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.busy) begin
                        r_dwell <= '0;
                        r_state <= r_exit ? S_IDLE : S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (r_dwell == DWELL_LAST) begin
                        if (r_cur == LAST_DIG) begin
                            r_cur <= '0;
                            r_fd  <= 1'b1;
                        end else begin
                            r_cur <= r_cur + 1'b1;
                        end
                        r_state <= bus.en ? S_LOAD : S_BLANK;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                S_BLANK: begin
                    r_data  <= OFF_WORD;
                    r_cur   <= '0;
                    r_exit  <= 1'b1;
                    r_state <= S_SEND;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_out   = r_data;
    assign bus.start      = r_start;
    assign bus.cur_digit  = r_cur;
    assign bus.frame_done = r_fd;
    assign bus.ack_err    = r_ack_err;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: shifter model, scoreboard of expected words.
// Latency: checks the dwell gap between busy falling and the next start.
// Backpressure: exercises held-off start (busy high) and a dead shifter.
module tb_seg_scan_driver;
    localparam int ND     = 4;
    localparam int SW     = 8;
    localparam int DWELL  = 4;
    localparam int ACK_TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(ND), .SEG_W(SW)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS(ND), .SEG_W(SW), .DWELL_CYCLES(DWELL),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [11:0] w;
        logic [1:0]  d;
    } exp_t;

    exp_t q[$];

    int n_err = 0, n_chk = 0;
    int cyc = 0, start_cnt = 0, fd_cnt = 0, fd_at_start = -1, viol = 0;
    int fall_cyc = 0, m_cnt = 0;
    bit fall_vld = 0, gap_en = 0, dead = 0, force_busy = 0, m_busy = 0, m_pend = 0;
    logic prev_start = 1'b0;

    assign bus.busy = m_busy | force_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected word with both polarities active-low: inverted code (or all
    // ones when blanked) over a one-cold digit select.
    task automatic push_frame(input logic [31:0] sb, input logic [3:0] bm, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            logic [3:0] sel;
            logic [7:0] code;
            sel  = 4'b0001 << i;
            code = sb[i*8 +: 8];
            e.w  = {(bm[i] ? 8'hFF : ~code), ~sel};
            e.d  = 2'(i);
            q.push_back(e);
        end
    endtask

    task automatic wait_starts(input int n);
        int t = 0;
        while (start_cnt < n && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("start_reached", (start_cnt >= n), 1);
    endtask

    task automatic wait_busy(input logic v);
        int t = 0;
        while (bus.busy !== v && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("busy_level", bus.busy, v);
    endtask

    // Monitor first (sees this cycle's outputs), then the shifter model:
    // busy rises one cycle after start is seen and stays high 16 cycles.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.start === 1'b1) begin
            start_cnt++;
            if (prev_start === 1'b1 || bus.busy === 1'b1) viol++;
            chk("sb_pending", (q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("word", bus.data_out, e.w);
                chk("digit", bus.cur_digit, e.d);
            end
            // busy drop -> WAIT_DONE sees it, DWELL cycles, LOAD, SEND, start
            if (gap_en && fall_vld) chk("dwell_gap", cyc - fall_cyc, DWELL + 3);
            fall_vld = 0;
        end
        prev_start = bus.start;
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            if (fd_at_start < 0) fd_at_start = start_cnt;
        end
        if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy   = 0;
                fall_cyc = cyc;
                fall_vld = 1;
            end
        end
        if (m_pend) begin
            m_pend = 0;
            m_busy = 1;
            m_cnt  = 16;
        end
        if (bus.start === 1'b1 && !dead) m_pend = 1;
    end

    localparam logic [31:0] SB_A = 32'h3F065B4F;
    localparam logic [31:0] SB_B = 32'h6D667D07;
    localparam logic [31:0] SB_C = 32'h7F6F7739;
    localparam logic [31:0] SB_D = 32'h5E79717C;

    initial begin
        exp_t off;
        bus.en = 1'b0;
        bus.seg_bus = '0;
        bus.blank_mask = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", bus.data_out, 12'hFFF);
        chk("rst_start", bus.start, 1'b0);
        chk("rst_cur", bus.cur_digit, 2'd0);
        chk("rst_ack_err", bus.ack_err, 1'b0);
        chk("rst_fd", bus.frame_done, 1'b0);
        rst = 1'b0;

        // Frame A, then B (digit 1 blanked) requested mid-frame A.
        push_frame(SB_A, 4'b0000, 4);
        gap_en = 1;
        bus.seg_bus = SB_A;
        bus.en = 1'b1;
        wait_starts(2);
        bus.seg_bus = SB_B;
        bus.blank_mask = 4'b0010;
        push_frame(SB_B, 4'b0010, 4);
        wait_starts(5);
        chk("fd_count_a", fd_cnt, 1);
        chk("fd_after_digit3", fd_at_start, 4);

        // Frame C requested mid-frame B; en dropped during digit 2 WAIT_DONE.
        wait_starts(6);
        bus.seg_bus = SB_C;
        bus.blank_mask = 4'b0000;
        push_frame(SB_C, 4'b0000, 3);
        off.w = 12'hFFF;
        off.d = 2'd0;
        q.push_back(off);
        wait_starts(11);
        wait_busy(1'b1);
        bus.en = 1'b0;
        wait_starts(12);
        wait_busy(1'b1);
        wait_busy(1'b0);
        gap_en = 0;
        repeat (30) begin @(posedge clk); #1; end
        chk("idle_no_start", start_cnt, 12);
        chk("idle_cur", bus.cur_digit, 2'd0);
        chk("idle_data", bus.data_out, 12'hFFF);
        chk("idle_sb_empty", q.size(), 0);

        // busy already high when SEND is reached: start must wait.
        force_busy = 1;
        bus.seg_bus = SB_D;
        push_frame(SB_D, 4'b0000, 4);
        bus.en = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("start_withheld", start_cnt, 12);
        force_busy = 0;
        wait_starts(13);
        wait_busy(1'b1);

        // Dead shifter on digit 1: ack_err exactly ACK_TO cycles after start.
        dead = 1;
        chk("ack_err_clear", bus.ack_err, 1'b0);
        wait_starts(14);
        repeat (ACK_TO - 2) @(posedge clk);
        #1;
        chk("ack_err_early", bus.ack_err, 1'b0);
        @(posedge clk); #1;
        chk("ack_err_set", bus.ack_err, 1'b1);
        dead = 0;

        // Scan continues; reset while digit 2 is in DWELL.
        wait_starts(15);
        wait_busy(1'b1);
        wait_busy(1'b0);
        chk("ack_err_sticky", bus.ack_err, 1'b1);
        chk("dwell_cur", bus.cur_digit, 2'd2);
        rst = 1'b1;
        bus.en = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_data", bus.data_out, 12'hFFF);
        chk("mid_rst_start", bus.start, 1'b0);
        chk("mid_rst_cur", bus.cur_digit, 2'd0);
        chk("mid_rst_ack_err", bus.ack_err, 1'b0);
        chk("mid_rst_fd", bus.frame_done, 1'b0);
        rst = 1'b0;
        q.delete();
        repeat (30) begin @(posedge clk); #1; end
        chk("post_rst_no_start", start_cnt, 15);
        chk("fd_total", fd_cnt, 2);
        chk("start_rules", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
